// File: rtl/mul_seq_32_pkg.sv
// mul_seq_32_pkg
//   Shared definitions for the iterative 32x32 multiplier: FSM state
//   encoding, iteration count and iteration-counter width.
package mul_seq_32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = 6;

endpackage

// File: rtl/add_pg_32.sv
// add_pg_32
//   32-bit two-level carry-lookahead adder (4-bit groups).
//   val1, val2 : operands
//   carry_in   : carry into bit 0
//   val_out    : sum
//   carry_out  : carry out of bit 31
//   prop_out   : whole-word propagate
//   gen_out    : whole-word generate
module add_pg_32 (
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic        carry_in,
    output logic [31:0] val_out,
    output logic        carry_out,
    output logic        prop_out,
    output logic        gen_out
);

    logic [31:0] g, p;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;
    logic [31:0] c;

    always_comb begin
        g  = val1 & val2;
        p  = val1 ^ val2;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        // group generate/propagate
        for (int b = 0; b < 8; b++) begin
            gp[b] = &p[4*b +: 4];
            gg[b] = g[4*b+3]
                  | (p[4*b+3] & g[4*b+2])
                  | (p[4*b+3] & p[4*b+2] & g[4*b+1])
                  | (p[4*b+3] & p[4*b+2] & p[4*b+1] & g[4*b]);
        end
        // carries into each group
        gc[0] = carry_in;
        for (int b = 0; b < 8; b++)
            gc[b+1] = gg[b] | (gp[b] & gc[b]);
        // carries inside each group start from the group carry
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0)
                    c[4*b] = gc[b];
                else
                    c[4*b+k] = g[4*b+k-1] | (p[4*b+k-1] & c[4*b+k-1]);
            end
        end
    end

    assign val_out   = p ^ c;
    assign carry_out = gc[8];
    assign prop_out  = &gp;
    // A fully propagating word cannot also generate, so the carry-out
    // with the propagate path masked off is the word generate.
    assign gen_out   = gc[8] & ~(&gp);

endmodule

// File: rtl/mul_seq_32.sv
// mul_seq_32
//   Iterative unsigned 32x32 -> 64 shift-and-add multiplier, one
//   iteration per cycle through add_pg_32, valid/ready on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (mcand, mplier)
//   out_valid/out_ready : result handshake (product, hi_nonzero)
//   hi_nonzero          : upper product word non-zero (32-bit overflow)
module mul_seq_32
    import mul_seq_32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        hi_nonzero
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        mc_q;
    logic [31:0]        acc_hi_q;
    logic [31:0]        acc_lo_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [63:0]        product_q;
    logic               hi_nz_q;

    logic [31:0]        sum;
    logic               cout;
    logic [63:0]        acc_d;

    add_pg_32 u_add (
        .val1      (acc_hi_q),
        .val2      (mc_q),
        .carry_in  (1'b0),
        .val_out   (sum),
        .carry_out (cout),
        .prop_out  (),
        .gen_out   ()
    );

    // 65-bit {carry, partial sum, multiplier remainder} shifted right one;
    // the carry lands in acc_hi[31] so no precision is lost.
    always_comb begin
        acc_d = {1'b0, acc_hi_q, acc_lo_q[31:1]};
        if (acc_lo_q[0])
            acc_d = {cout, sum, acc_lo_q[31:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mc_q        <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            hi_nz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mc_q       <= mcand;
                        acc_hi_q   <= '0;
                        acc_lo_q   <= mplier;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_hi_q <= acc_d[63:32];
                    acc_lo_q <= acc_d[31:0];
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
                        product_q   <= acc_d;
                        hi_nz_q     <= |acc_d[63:32];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign product    = product_q;
    assign hi_nonzero = hi_nz_q;

endmodule

// File: tb/tb_mul_seq_32.sv
module tb_mul_seq_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        hi_nonzero;

    int n_vec;
    int n_bad;

    mul_seq_32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mcand      (mcand),
        .mplier     (mplier),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .hi_nonzero (hi_nonzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        bit          noise;
        logic [63:0] exp_p;
        logic        exp_hz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Run one multiply: accept, measure latency, hold the result for
    // 'stall' cycles with out_ready low, then retire it.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                         input bit noise, input logic [63:0] exp_p, input logic exp_hz);
        int lat;
        int w;
        logic [63:0] held;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        mcand    = a;
        mplier   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            // operands change after acceptance; result must not care
            mcand  = $urandom;
            mplier = $urandom;
            if (noise) begin
                in_valid = 1'b1;
                chk("in_ready_busy", 64'(in_ready), 64'd0);
            end
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end
        chk("latency", 64'(lat), 64'd32);
        chk("product", product, exp_p);
        chk("hi_nonzero", 64'(hi_nonzero), 64'(exp_hz));
        held = product;
        for (int s = 0; s < stall; s++) begin
            if (noise) in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (noise) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_product", product, held);
                chk("hold_in_ready", 64'(in_ready), 64'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (noise || stall == 0) begin
            chk("retire_valid", 64'(out_valid), 64'd0);
            chk("retire_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    vec_t tbl[$];

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mcand     = '0;
        mplier    = '0;

        tbl.push_back('{32'd3,          32'd5,          0,  1'b0, 64'd15,                  1'b0});
        tbl.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   0,  1'b0, 64'hFFFFFFFE_00000001,   1'b1});
        tbl.push_back('{32'h12345678,   32'd0,          0,  1'b0, 64'd0,                   1'b0});
        tbl.push_back('{32'h12345678,   32'd1,          0,  1'b0, 64'h00000000_12345678,   1'b0});
        tbl.push_back('{32'h00010000,   32'h00010000,   10, 1'b1, 64'h00000001_00000000,   1'b1});
        tbl.push_back('{32'h80000000,   32'd2,          2,  1'b0, 64'h00000001_00000000,   1'b1});
        tbl.push_back('{32'hFFFFFFFF,   32'd1,          0,  1'b0, 64'h00000000_FFFFFFFF,   1'b0});

        repeat (2) @(negedge clk);
        chk("rst_in_ready",   64'(in_ready),   64'd1);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_product",    product,         64'd0);
        chk("rst_hi_nonzero", 64'(hi_nonzero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i])
            do_op(tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].noise, tbl[i].exp_p, tbl[i].exp_hz);

        // Reset in the middle of an operation: discard it entirely.
        mcand    = 32'hDEADBEEF;
        mplier   = 32'hCAFEF00D;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",   64'(in_ready),   64'd1);
        chk("midrst_out_valid",  64'(out_valid),  64'd0);
        chk("midrst_product",    product,         64'd0);
        chk("midrst_hi_nonzero", 64'(hi_nonzero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(32'd7, 32'd9, 0, 1'b0, 64'd63, 1'b0);

        // Random regression against plain 64-bit arithmetic.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [63:0] ref_p;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'hFFFFFFFF;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(0, 3);
                default: ;
            endcase
            ref_p = 64'(a) * 64'(b);
            do_op(a, b, $urandom_range(0, 3), 1'b0, ref_p, ref_p[63:32] != 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
